// File: rtl/input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// input_conditioner_pkg
// Shared constants and helpers for the input conditioner.
//   - clog2_min1 : counter-width helper that never returns 0
//   - DEFAULT_SAMPLE_CNT_MAX : ~0.5 ms tick on the 125 MHz board clock
//   - DEFAULT_PULSE_CNT_MAX  : ~100 ms debounce window at that tick rate
// ---------------------------------------------------------------------------
package input_conditioner_pkg;

    localparam int DEFAULT_SAMPLE_CNT_MAX = 62500;
    localparam int DEFAULT_PULSE_CNT_MAX  = 200;

    // $clog2 returns 0 for a value of 1; a counter still needs one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One debounce channel: a saturating pulse counter plus the debounced level
// register and registered edge pulses.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   tick     : shared sample tick, one cycle wide
//   sync_bit : synchronized input bit
//   level    : debounced level
//   rise     : one-cycle pulse in the first cycle level reads 1
//   fall     : one-cycle pulse in the first cycle level reads 0
// ---------------------------------------------------------------------------
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int PULSE_CNT_MAX = DEFAULT_PULSE_CNT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sync_bit,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2_min1(PULSE_CNT_MAX + 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_flip;

    // Flip on the tick that completes PULSE_CNT_MAX consecutive disagreements.
    assign w_flip = tick && (sync_bit != r_level) && (r_cnt == CW'(PULSE_CNT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            // Edge pulses are registered alongside the level so they line up
            // with the first cycle of the new level.
            r_rise <= w_flip && !r_level;
            r_fall <= w_flip &&  r_level;
            if (tick) begin
                if (sync_bit == r_level) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Synchronizes WIDTH asynchronous inputs through SYNC_STAGES flops, then
// debounces each with a shared sample tick and per-channel counters.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   async_in  : raw asynchronous inputs [WIDTH]
//   level_out : debounced levels [WIDTH]
//   rise_out  : one-cycle rising-edge pulses [WIDTH]
//   fall_out  : one-cycle falling-edge pulses [WIDTH]
// ---------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out
);

    localparam int SCW = clog2_min1(SAMPLE_CNT_MAX);

    // Stage 0 captures async_in; stage SYNC_STAGES-1 feeds the debouncers.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync;
    logic [SCW-1:0]                    r_sample_cnt;
    logic                              w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // With SAMPLE_CNT_MAX = 1 the counter sits at 0 and tick is constant high.
    assign w_tick = (r_sample_cnt == SCW'(SAMPLE_CNT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= '0;
        end else if (w_tick) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + SCW'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_channel #(
            .PULSE_CNT_MAX(PULSE_CNT_MAX)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (w_tick),
            .sync_bit(w_sync[g]),
            .level   (level_out[g]),
            .rise    (rise_out[g]),
            .fall    (fall_out[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
// Directed bench for input_conditioner with WIDTH=2, SYNC_STAGES=2,
// SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3. After a reset release the first tick
// lands on the 4th clock edge, so a held change applied just after release
// flips level_out on edge 12 (2 sync + ticks at edges 4, 8, 12).
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] async_in;
    logic [1:0] level_out;
    logic [1:0] rise_out;
    logic [1:0] fall_out;

    int vectors;
    int miscompares;

    input_conditioner #(
        .WIDTH         (2),
        .SYNC_STAGES   (2),
        .SAMPLE_CNT_MAX(4),
        .PULSE_CNT_MAX (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .async_in (async_in),
        .level_out(level_out),
        .rise_out (rise_out),
        .fall_out (fall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        async_in = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        async_in = 2'b11;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({level_out, rise_out, fall_out} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold cyc%0d: lvl=%b rise=%b fall=%b, want all 0",
                         c, level_out, rise_out, fall_out);
            end
        end
        rst = 1'b0;
        step();
        vectors++;
        if (level_out !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: level_out=%b, want 00", level_out);
        end
    endtask

    task automatic test_press();
        int first_lvl, rise_cnt, rise_cyc, bad;
        first_lvl = -1; rise_cnt = 0; rise_cyc = -1; bad = 0;
        do_reset();
        async_in = 2'b01;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (level_out[0] && first_lvl < 0) first_lvl = c;
            if (rise_out[0]) begin rise_cnt++; rise_cyc = c; end
            if (fall_out[0] || level_out[1] || rise_out[1] || fall_out[1]) bad++;
        end
        vectors++;
        if (first_lvl < 10 || first_lvl > 18) begin
            miscompares++;
            $display("FAIL press_window: flip at cycle %0d, want 10..18", first_lvl);
        end
        vectors++;
        if (first_lvl != 12) begin
            miscompares++;
            $display("FAIL press_latency: flip at cycle %0d, want 12", first_lvl);
        end
        vectors++;
        if (rise_cnt != 1 || rise_cyc != first_lvl) begin
            miscompares++;
            $display("FAIL press_rise: %0d pulses at cycle %0d, want 1 at cycle %0d",
                     rise_cnt, rise_cyc, first_lvl);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL press_quiet: %0d bad cycles on fall0/ch1, want 0", bad);
        end
        vectors++;
        if (level_out !== 2'b01) begin
            miscompares++;
            $display("FAIL press_hold: level_out=%b, want 01", level_out);
        end
    endtask

    // Continues from the pressed state left by test_press.
    task automatic test_release();
        int fall_cnt, fall_cyc, rise_cnt;
        fall_cnt = 0; fall_cyc = -1; rise_cnt = 0;
        async_in = 2'b00;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (fall_out[0]) begin fall_cnt++; fall_cyc = c; end
            if (rise_out != 2'b00 || (rise_out & fall_out) != 2'b00) rise_cnt++;
        end
        vectors++;
        if (fall_cnt != 1 || fall_cyc > 18) begin
            miscompares++;
            $display("FAIL release_fall: %0d pulses, last at cycle %0d, want 1 by cycle 18",
                     fall_cnt, fall_cyc);
        end
        vectors++;
        if (rise_cnt != 0) begin
            miscompares++;
            $display("FAIL release_norise: %0d cycles with rise, want 0", rise_cnt);
        end
        vectors++;
        if (level_out !== 2'b00) begin
            miscompares++;
            $display("FAIL release_level: level_out=%b, want 00", level_out);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        do_reset();
        async_in = 2'b01;
        for (int c = 0; c < 5; c++) step();
        async_in = 2'b00;
        for (int c = 0; c < 40; c++) begin
            step();
            if (level_out[0] || rise_out[0] || fall_out[0]) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL glitch: %0d cycles with activity on ch0, want 0", bad);
        end
    endtask

    task automatic test_simultaneous();
        int pulses, pulse_cyc;
        logic [1:0] seen;
        pulses = 0; pulse_cyc = -1; seen = 2'b00;
        do_reset();
        async_in = 2'b11;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (rise_out != 2'b00) begin
                pulses++; pulse_cyc = c; seen = rise_out;
            end
        end
        vectors++;
        if (pulses != 1 || seen !== 2'b11) begin
            miscompares++;
            $display("FAIL simul_rise: %0d pulse cycles, rise_out=%b, want 1 cycle of 11",
                     pulses, seen);
        end
        vectors++;
        if (pulse_cyc != 12) begin
            miscompares++;
            $display("FAIL simul_cycle: pulse at cycle %0d, want 12", pulse_cyc);
        end
        vectors++;
        if (level_out !== 2'b11) begin
            miscompares++;
            $display("FAIL simul_level: level_out=%b, want 11", level_out);
        end
    endtask

    task automatic test_reset_mid();
        int first_lvl, falls;
        first_lvl = -1; falls = 0;
        do_reset();
        async_in = 2'b10;
        for (int c = 0; c < 8; c++) begin
            step();
            if (fall_out != 2'b00) falls++;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (level_out[1] && first_lvl < 0) first_lvl = c;
            if (fall_out != 2'b00) falls++;
        end
        vectors++;
        if (first_lvl < 10 || first_lvl != 12) begin
            miscompares++;
            $display("FAIL resetmid_restart: flip at cycle %0d, want 12 (>=10)", first_lvl);
        end
        // Reset with level high: level drops, no fall pulse.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (fall_out != 2'b00) falls++;
        end
        vectors++;
        if (level_out !== 2'b00) begin
            miscompares++;
            $display("FAIL resetmid_level: level_out=%b, want 00", level_out);
        end
        rst = 1'b0;
        async_in = 2'b00;
        for (int c = 0; c < 20; c++) begin
            step();
            if (fall_out != 2'b00) falls++;
        end
        vectors++;
        if (falls != 0) begin
            miscompares++;
            $display("FAIL resetmid_nofall: %0d fall cycles, want 0", falls);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        async_in    = 2'b00;
        test_reset();
        test_press();
        test_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised successor to the plain 2-flop synchronizer.
- Takes WIDTH independent asynchronous inputs (buttons, switches, off-domain levels) through a configurable-depth synchronizer chain, then debounces them with a shared sample tick and per-channel saturating counters.
- Per channel it emits a clean debounced level plus one-cycle rising and falling edge pulses.
- Sits between board I/O and all control logic on the single system clock.

Parameters:
- WIDTH, 1: number of independent channels.
- SYNC_STAGES, 2: flip-flops in each synchronizer chain; legal range is 2 or more.
- SAMPLE_CNT_MAX, 62500: clock cycles between debounce sample ticks; legal range is 1 or more.
- PULSE_CNT_MAX, 200: consecutive disagreeing ticks required to flip the debounced level; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- async_in  input  WIDTH  asynchronous raw inputs; no timing relation to clk.
- level_out  output  WIDTH  debounced, synchronized level per channel.
- rise_out  output  WIDTH  one-cycle pulse on a 0->1 transition of level_out.
- fall_out  output  WIDTH  one-cycle pulse on a 1->0 transition of level_out.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high. While rst is sampled high at a clk edge, every register clears:
  - sync chains = 0
  - sample counter = 0
  - all pulse counters = 0
  - level_out = 0, rise_out = 0, fall_out = 0
- Reset mid-operation: identical to reset from power-up. A level of 1 returns to 0 without producing a fall_out pulse.
- Sync chain: per bit, a shift register of SYNC_STAGES flops. sync[i] is the last stage. No logic sits between stages.
- Sample counter: width $clog2(SAMPLE_CNT_MAX) (minimum 1).
  - Counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - tick = 1 in the cycle the counter equals SAMPLE_CNT_MAX-1.
  - With SAMPLE_CNT_MAX = 1, tick is high every cycle.
  - One counter is shared by all channels.
- Per-channel pulse counter: width $clog2(PULSE_CNT_MAX+1). Updates only on tick cycles:
  - If sync[i] == level_out[i]: counter := 0.
  - Else if counter == PULSE_CNT_MAX-1: level_out[i] := ~level_out[i] and counter := 0 (flip).
  - Else: counter := counter + 1.
  - The counter never exceeds PULSE_CNT_MAX-1, so it cannot wrap.
- Edge outputs: registered.
  - rise_out[i] is high in exactly the cycle level_out[i] first reads 1 after a flip, and low otherwise. fall_out mirrors this for 0.
  - rise_out[i] and fall_out[i] are never high together.
  - Pulses on different channels are independent and may coincide.
- Latency from a stable change on async_in[i] to the level_out[i] flip:
  - minimum SYNC_STAGES + (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX + 1 cycles
  - maximum SYNC_STAGES + PULSE_CNT_MAX*SAMPLE_CNT_MAX + 1 cycles
- Glitch rejection: any excursion spanning fewer than PULSE_CNT_MAX ticks produces no flip and no pulse.
- Input toggling on every cycle: no pulses. Only consecutive disagreeing ticks count.

Decomposition:
- Shared package/header holds:
  - a clog2-with-minimum-1 helper
  - default SAMPLE_CNT_MAX and PULSE_CNT_MAX constants for the 125 MHz board clock (~0.5 ms tick, ~100 ms debounce)
- The top level owns the sync chains and the shared sample counter.
- One sub-module, debounce_channel (inputs: clk, rst, tick, sync bit; outputs: level, rise, fall), holds one pulse counter and its level register. It is instantiated WIDTH times in a generate loop.

Test Plan:
(all with WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3)
- Reset: assert rst for 3 cycles with async_in=2'b11, release -> all outputs 0 during reset; level_out=0 on the first cycle after release.
- Clean press: async_in[0] 0->1 at cycle 0 and held -> level_out[0]=1 no earlier than cycle 10 and by cycle 18; rise_out[0] high exactly one cycle, coincident with the first cycle of level_out[0]=1; channel 1 stays 0.
- Glitch: async_in[0] high for 5 cycles, then low -> level_out[0], rise_out[0] and fall_out[0] remain 0 for 40 cycles.
- Release: after the press above, drop async_in[0] -> fall_out[0] one-cycle pulse within 18 cycles; level_out[0]=0 afterwards.
- Simultaneous: both bits rise in the same cycle -> rise_out=2'b11 in the same single cycle.
- Reset mid-count: drive async_in[1] high, assert rst 8 cycles in, release -> counter restarts; level_out[1] rises no earlier than 10 cycles after release and no fall_out pulse ever occurs.
